// File: rtl/alzette_seq.sv
// rtl/alzette_seq.sv - multi-cycle Alzette ARX-box sequencer with step datapath
//
// alzette_ise_v2: one combinational Alzette step (forward or inverse).
//   rs      in  64  {y, x} state in
//   rc      in  32  round constant
//   imm     in  2   step index 0..3, selects the rotation pair
//   op_enc  in  1   1 = forward step, 0 = inverse step
//   rd      out 64  {y, x} state out
//
// alzette_seq: runs the four steps of one Alzette box, ROUNDS_PER_CYCLE per clock.
//   g_clk      in  1   clock, rising edge
//   g_resetn   in  1   asynchronous active-low reset
//   abort      in  1   synchronous kill of the in-flight op
//   req_valid  in  1   request present
//   req_ready  out 1   sequencer can accept
//   req_enc    in  1   1 = encrypt, 0 = decrypt
//   req_x      in  32  input x word
//   req_y      in  32  input y word
//   req_c      in  32  round constant
//   rsp_valid  out 1   result present
//   rsp_ready  in  1   consumer accepts
//   rsp_x      out 32  result x word
//   rsp_y      out 32  result y word
//   busy       out 1   sequencer not idle

module alzette_ise_v2 (
  input  logic [63:0] rs,
  input  logic [31:0] rc,
  input  logic [1:0]  imm,
  input  logic        op_enc,
  output logic [63:0] rd
);

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    logic [5:0] m;
    m = 6'd32 - {1'b0, n};
    // A shift by 32 yields zero, so n == 0 returns v unchanged.
    return (v >> n) | (v << m);
  endfunction

  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [4:0]  rot_r;
  logic [4:0]  rot_s;
  logic [31:0] a_enc;
  logic [31:0] b_enc;
  logic [31:0] a_dec;
  logic [31:0] b_dec;

  assign x_in = rs[31:0];
  assign y_in = rs[63:32];

  always_comb begin
    rot_r = 5'd31;
    rot_s = 5'd24;
    case (imm)
      2'd0: begin rot_r = 5'd31; rot_s = 5'd24; end
      2'd1: begin rot_r = 5'd17; rot_s = 5'd17; end
      2'd2: begin rot_r = 5'd0;  rot_s = 5'd31; end
      default: begin rot_r = 5'd24; rot_s = 5'd16; end
    endcase
  end

  // Forward: x += ror(y,r); y ^= ror(x,s); x ^= c.
  assign a_enc = x_in + ror32(y_in, rot_r);
  assign b_enc = y_in ^ ror32(a_enc, rot_s);

  // Inverse undoes the three operations in reverse order.
  assign a_dec = x_in ^ rc;
  assign b_dec = y_in ^ ror32(a_dec, rot_s);

  assign rd = op_enc ? {b_enc, a_enc ^ rc}
                     : {b_dec, a_dec - ror32(b_dec, rot_r)};

endmodule

module alzette_seq #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        abort,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_enc,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [31:0] req_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_x,
  output logic [31:0] rsp_y,
  output logic        busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_param
    $error("alzette_seq: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  step_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] c_q;
  logic        enc_q;

  logic        req_fire;
  logic        step_last;
  logic [63:0] chain [0:R];

  // Steps k..k+R-1 are chained combinationally; decrypt walks the
  // step indices backwards (3-k is the bitwise complement of k).
  assign chain[0] = {y_q, x_q};

  for (genvar i = 0; i < R; i++) begin : g_step
    logic [1:0] k;
    logic [1:0] imm;
    assign k   = step_q + 2'(i);
    assign imm = enc_q ? k : ~k;

    alzette_ise_v2 u_step (
      .rs     (chain[i]),
      .rc     (c_q),
      .imm    (imm),
      .op_enc (enc_q),
      .rd     (chain[i+1])
    );
  end

  assign step_last = (({1'b0, step_q} + 3'(R)) == 3'd4);

  // DONE offers req_ready only while the result is retired in the same
  // cycle, which lets DONE go straight to RUN. abort masks acceptance.
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_DONE: req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
    if (abort) req_ready = 1'b0;
  end

  assign req_fire  = req_valid & req_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_x     = x_q;
  assign rsp_y     = y_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      c_q     <= 32'd0;
      enc_q   <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            x_q     <= req_x;
            y_q     <= req_y;
            c_q     <= req_c;
            enc_q   <= req_enc;
            step_q  <= 2'd0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          x_q <= chain[R][31:0];
          y_q <= chain[R][63:32];
          if (step_last) begin
            step_q  <= 2'd0;
            state_q <= ST_DONE;
          end else begin
            step_q  <= step_q + 2'(R);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            if (req_fire) begin
              x_q     <= req_x;
              y_q     <= req_y;
              c_q     <= req_c;
              enc_q   <= req_enc;
              step_q  <= 2'd0;
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alzette_seq.sv
// tb/tb_alzette_seq.sv - directed self-checking bench for alzette_seq

module tb_alzette_seq;

  localparam logic [31:0] KAT_C = 32'hB7E15162;
  localparam logic [31:0] KAT_X = 32'h44DD4DE9;
  localparam logic [31:0] KAT_Y = 32'hE5581F2D;

  logic        g_clk;
  logic        g_resetn;
  logic        abort;
  logic        req_valid;
  logic        req_enc;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [31:0] req_c;
  logic        rsp_ready;

  logic        req_ready,  rsp_valid,  busy;
  logic [31:0] rsp_x,  rsp_y;
  logic        req_ready2, rsp_valid2, busy2;
  logic [31:0] rsp_x2, rsp_y2;
  logic        req_ready4, rsp_valid4, busy4;
  logic [31:0] rsp_x4, rsp_y4;

  int errors = 0;
  int checks = 0;

  alzette_seq #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc),
    .req_x(req_x), .req_y(req_y), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy)
  );

  alzette_seq #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .g_clk(g_clk), .g_resetn(g_resetn), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready2), .req_enc(req_enc),
    .req_x(req_x), .req_y(req_y), .req_c(req_c),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x2), .rsp_y(rsp_y2), .busy(busy2)
  );

  alzette_seq #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready4), .req_enc(req_enc),
    .req_x(req_x), .req_y(req_y), .req_c(req_c),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x4), .rsp_y(rsp_y4), .busy(busy4)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Issues one request to an idle R=1 sequencer, waits (bounded) for the
  // result, retires it and reports latency in edges after the accept edge.
  task automatic run_op(input logic enc, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] c, output logic [31:0] rx,
                        output logic [31:0] ry, output int lat);
    @(negedge g_clk);
    req_valid = 1'b1; req_enc = enc; req_x = x; req_y = y; req_c = c;
    rsp_ready = 1'b0;
    @(negedge g_clk);
    req_valid = 1'b0;
    lat = -1;
    rx = 32'hx; ry = 32'hx;
    for (int n = 0; n <= 20; n++) begin
      if (rsp_valid) begin
        lat = n;
        rx = rsp_x;
        ry = rsp_y;
        break;
      end
      @(negedge g_clk);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    abort = 1'b0; req_valid = 1'b0; req_enc = 1'b0;
    req_x = 32'd0; req_y = 32'd0; req_c = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge g_clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_valid_busy got=%b%b exp=00", rsp_valid, busy);
    end
    checks++;
    if (rsp_x !== 32'd0 || rsp_y !== 32'd0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", rsp_x, rsp_y);
    end
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  task automatic test_zeros();
    logic [31:0] rx, ry; int lat;
    run_op(1'b1, 32'd0, 32'd0, 32'd0, rx, ry, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL zeros_latency got=%0d exp=4", lat); end
    checks++;
    if (rx !== 32'd0 || ry !== 32'd0) begin errors++; $display("FAIL zeros_data got=%h/%h exp=0/0", rx, ry); end
  endtask

  task automatic test_kat();
    logic [31:0] rx, ry; int lat;
    run_op(1'b1, 32'd0, 32'd0, KAT_C, rx, ry, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL kat_enc_latency got=%0d exp=4", lat); end
    checks++;
    if (rx !== KAT_X || ry !== KAT_Y) begin
      errors++; $display("FAIL kat_enc got=%h/%h exp=%h/%h", rx, ry, KAT_X, KAT_Y);
    end
    run_op(1'b0, KAT_X, KAT_Y, KAT_C, rx, ry, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL kat_dec_latency got=%0d exp=4", lat); end
    checks++;
    if (rx !== 32'd0 || ry !== 32'd0) begin
      errors++; $display("FAIL kat_dec got=%h/%h exp=0/0", rx, ry);
    end
  endtask

  task automatic test_rounds();
    logic ev1, ev2, ev4;
    @(negedge g_clk);
    abort = 1'b1;
    @(negedge g_clk);
    abort = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_enc = 1'b1; req_x = 32'd0; req_y = 32'd0; req_c = KAT_C;
    @(negedge g_clk);
    req_valid = 1'b0;
    for (int n = 0; n <= 4; n++) begin
      ev1 = (n >= 4); ev2 = (n >= 2); ev4 = (n >= 1);
      checks++;
      if (rsp_valid !== ev1 || rsp_valid2 !== ev2 || rsp_valid4 !== ev4) begin
        errors++;
        $display("FAIL rounds_latency edge=%0d got(r1,r2,r4)=%b%b%b exp=%b%b%b",
                 n, rsp_valid, rsp_valid2, rsp_valid4, ev1, ev2, ev4);
      end
      if (n < 4) @(negedge g_clk);
    end
    checks++;
    if (rsp_x2 !== KAT_X || rsp_y2 !== KAT_Y) begin
      errors++; $display("FAIL rounds_r2_data got=%h/%h exp=%h/%h", rsp_x2, rsp_y2, KAT_X, KAT_Y);
    end
    checks++;
    if (rsp_x4 !== KAT_X || rsp_y4 !== KAT_Y) begin
      errors++; $display("FAIL rounds_r4_data got=%h/%h exp=%h/%h", rsp_x4, rsp_y4, KAT_X, KAT_Y);
    end
    checks++;
    if (rsp_x !== KAT_X || rsp_y !== KAT_Y) begin
      errors++; $display("FAIL rounds_r1_data got=%h/%h exp=%h/%h", rsp_x, rsp_y, KAT_X, KAT_Y);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || busy2 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL rounds_retire busy(r1,r2,r4)=%b%b%b exp=000", busy, busy2, busy4);
    end
  endtask

  task automatic test_round_trip();
    logic [31:0] x, y, c, ex, ey, dx, dy; int lat_e, lat_d;
    for (int i = 0; i < 200; i++) begin
      x = $urandom; y = $urandom; c = $urandom;
      run_op(1'b1, x, y, c, ex, ey, lat_e);
      run_op(1'b0, ex, ey, c, dx, dy, lat_d);
      checks++;
      if (lat_e !== 4 || lat_d !== 4 || dx !== x || dy !== y) begin
        errors++;
        $display("FAIL round_trip i=%0d got=%h/%h lat=%0d/%0d exp=%h/%h lat=4/4",
                 i, dx, dy, lat_e, lat_d, x, y);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_enc = 1'b1; req_x = 32'd0; req_y = 32'd0; req_c = KAT_C;
    @(negedge g_clk);
    req_valid = 1'b0;
    // Inputs after the accept edge must not disturb the op in flight.
    req_enc = 1'b0; req_x = 32'hFFFFFFFF; req_y = 32'h12345678; req_c = 32'hDEADBEEF;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge g_clk); n++; end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_first_latency got=%0d exp=4", n); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_x !== KAT_X || rsp_y !== KAT_Y) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b %h/%h exp v=1 rdy=0 %h/%h",
                 i, rsp_valid, req_ready, rsp_x, rsp_y, KAT_X, KAT_Y);
      end
      @(negedge g_clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_enc = 1'b0; req_x = KAT_X; req_y = KAT_Y; req_c = KAT_C;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_overlap_ready got=%b exp=1", req_ready); end
    @(negedge g_clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_overlap_accept got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge g_clk); n++; end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_second_latency got=%0d exp=4", n); end
    checks++;
    if (rsp_x !== 32'd0 || rsp_y !== 32'd0) begin
      errors++; $display("FAIL bp_second_data got=%h/%h exp=0/0", rsp_x, rsp_y);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] rx, ry; int lat;
    logic seen;
    @(negedge g_clk);
    req_valid = 1'b1; req_enc = 1'b1; req_x = 32'd0; req_y = 32'd0; req_c = KAT_C;
    @(negedge g_clk);
    req_valid = 1'b0;
    @(negedge g_clk);
    abort = 1'b1; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_req_ready got=%b exp=0", req_ready); end
    @(negedge g_clk);
    abort = 1'b0; req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b v=%b exp 0/0", busy, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge g_clk);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got=1 exp=0"); end
    run_op(1'b1, 32'd0, 32'd0, KAT_C, rx, ry, lat);
    checks++;
    if (lat !== 4 || rx !== KAT_X || ry !== KAT_Y) begin
      errors++; $display("FAIL abort_next_op got=%h/%h lat=%0d exp=%h/%h lat=4", rx, ry, lat, KAT_X, KAT_Y);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rx, ry; int lat;
    @(negedge g_clk);
    req_valid = 1'b1; req_enc = 1'b1; req_x = 32'h01234567; req_y = 32'h89ABCDEF; req_c = KAT_C;
    @(negedge g_clk);
    req_valid = 1'b0;
    @(negedge g_clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
    #2 g_resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        rsp_x !== 32'd0 || rsp_y !== 32'd0) begin
      errors++;
      $display("FAIL areset_values got busy=%b v=%b rdy=%b %h/%h exp 0 0 1 0/0",
               busy, rsp_valid, req_ready, rsp_x, rsp_y);
    end
    @(negedge g_clk);
    g_resetn = 1'b1;
    run_op(1'b0, KAT_X, KAT_Y, KAT_C, rx, ry, lat);
    checks++;
    if (lat !== 4 || rx !== 32'd0 || ry !== 32'd0) begin
      errors++; $display("FAIL areset_next_op got=%h/%h lat=%0d exp=0/0 lat=4", rx, ry, lat);
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_kat();
    test_rounds();
    test_round_trip();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
